// File: rtl/alu_ops_pkg.sv
// Shared ALU operation codes and the divide sequencer state type.
package alu_ops_pkg;

   localparam int ALUCONTROL_WIDTH = 6;
   localparam logic [ALUCONTROL_WIDTH-1:0] UDIV_OP = 6'b101110;
   localparam logic [ALUCONTROL_WIDTH-1:0] SDIV_OP = 6'b101111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   function automatic logic is_div_op(input logic [ALUCONTROL_WIDTH-1:0] op);
      return (op == UDIV_OP) || (op == SDIV_OP);
   endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on a remainder:quotient pair.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;

   // Shift in the next dividend bit, trial-subtract, restore on borrow.
   always_comb begin
      shifted_s = {rem, quo[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, divisor};
      if (diff_s[WIDTH]) begin
         rem_next = shifted_s[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_next = diff_s[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle UDIV/SDIV sequencer with pipeline stall request.
// Optional build macro DIV_EARLY_TERM_EN skips iteration when the quotient is trivially zero.
module div_sequencer
   import alu_ops_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
   input  logic [WIDTH-1:0]            SrcAE,
   input  logic [WIDTH-1:0]            SrcBE,
   input  logic                        cancel,
   output logic                        busy,
   output logic                        done,
   output logic [WIDTH-1:0]            QuotientE,
   output logic [WIDTH-1:0]            RemainderE,
   output logic                        div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
   logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, zero_q, zero_d;
   logic [WIDTH-1:0] quo_out_q, quo_out_d, rem_out_q, rem_out_d;
   logic             dbz_q, dbz_d;

   logic             is_sdiv_s, accept_s, finish_s;
   logic [WIDTH-1:0] mag_a_s, mag_b_s, rem_step_s, quo_step_s, res_q_s, res_r_s;

   assign is_sdiv_s = (ALUControlE == SDIV_OP);
   assign accept_s  = start & ~cancel & (state_q == IDLE) & is_div_op(ALUControlE);
   assign mag_a_s   = (is_sdiv_s & SrcAE[WIDTH-1]) ? (WIDTH'(0) - SrcAE) : SrcAE;
   assign mag_b_s   = (is_sdiv_s & SrcBE[WIDTH-1]) ? (WIDTH'(0) - SrcBE) : SrcBE;

   // A zero divisor reports the original dividend rather than the iteration result.
   assign res_q_s  = zero_q ? '0 : (q_neg_q ? (WIDTH'(0) - quo_q) : quo_q);
   assign res_r_s  = zero_q ? dvd_q : (r_neg_q ? (WIDTH'(0) - rem_q) : rem_q);
   assign finish_s = (state_q == DONE) & ~cancel;

   assign busy        = accept_s | ((state_q == BUSY) & ~cancel);
   assign done        = finish_s;
   assign QuotientE   = finish_s ? res_q_s : quo_out_q;
   assign RemainderE  = finish_s ? res_r_s : rem_out_q;
   assign div_by_zero = finish_s ? zero_q  : dbz_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvs_q),
      .rem_next (rem_step_s),
      .quo_next (quo_step_s)
   );

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      dvd_d     = dvd_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      zero_d    = zero_q;
      quo_out_d = quo_out_q;
      rem_out_d = rem_out_q;
      dbz_d     = dbz_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               rem_d   = '0;
               quo_d   = mag_a_s;
               dvs_d   = mag_b_s;
               dvd_d   = SrcAE;
               q_neg_d = is_sdiv_s & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
               r_neg_d = is_sdiv_s & SrcAE[WIDTH-1];
               zero_d  = (SrcBE == '0);
               cnt_d   = CNT_W'(WIDTH);
               state_d = BUSY;
`ifdef DIV_EARLY_TERM_EN
               // Loading the magnitude as the remainder makes sign correction yield the dividend.
               if ((SrcBE == '0) || (mag_a_s < mag_b_s)) begin
                  rem_d   = mag_a_s;
                  quo_d   = '0;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cancel) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               rem_d   = rem_step_s;
               quo_d   = quo_step_s;
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q == CNT_W'(1)) ? DONE : BUSY;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!cancel) begin
               quo_out_d = res_q_s;
               rem_out_d = res_r_s;
               dbz_d     = zero_q;
            end else begin
               dbz_d     = dbz_q;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         dvd_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         zero_q    <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         dvd_q     <= dvd_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         zero_q    <= zero_d;
         quo_out_q <= quo_out_d;
         rem_out_q <= rem_out_d;
         dbz_q     <= dbz_d;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed-vector bench for div_sequencer (WIDTH=32), hand-computed expectations.
module tb_div_sequencer;
   import alu_ops_pkg::*;

   localparam logic [5:0] ADD_OP = 6'b100000;

   logic        clk = 1'b0;
   logic        reset, start, cancel;
   logic [5:0]  ALUControlE;
   logic [31:0] SrcAE, SrcBE;
   logic        busy, done, div_by_zero;
   logic [31:0] QuotientE, RemainderE;

   int n_vec = 0;
   int n_err = 0;

   div_sequencer #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .ALUControlE (ALUControlE),
      .SrcAE       (SrcAE),
      .SrcBE       (SrcBE),
      .cancel      (cancel),
      .busy        (busy),
      .done        (done),
      .QuotientE   (QuotientE),
      .RemainderE  (RemainderE),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_lat(input bit early);
`ifdef DIV_EARLY_TERM_EN
      return early ? 1 : 33;
`else
      return 33;
`endif
   endfunction

   // Issue one divide, follow it cycle by cycle and check latency, busy span and results.
   task automatic do_div(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input bit early, input bit hold);
      int lat, busy_cnt, done_cnt, done_cyc;
      lat = exp_lat(early);
      busy_cnt = 0; done_cnt = 0; done_cyc = -1;
      start = 1'b1; ALUControlE = op; SrcAE = a; SrcBE = b;
      @(negedge clk);
      check({tag, "_accept_busy"}, 32'(busy), 32'd1);
      if (busy) busy_cnt++;
      for (int k = 1; k <= lat + 3; k++) begin
         tick();
         if (!hold || k > lat) start = 1'b0;
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = k;
               check({tag, "_q"}, QuotientE, eq);
               check({tag, "_r"}, RemainderE, er);
               check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
            end
         end
      end
      check({tag, "_latency"}, 32'(done_cyc), 32'(lat));
      check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
      check({tag, "_q_hold"}, QuotientE, eq);
      check({tag, "_r_hold"}, RemainderE, er);
      tick();
   endtask

   // Count done pulses over a window with start low.
   task automatic expect_quiet(input string tag, input int cycles);
      int cnt;
      cnt = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (done) cnt++;
         tick();
      end
      check({tag, "_no_done"}, 32'(cnt), 32'd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; cancel = 1'b0;
      ALUControlE = '0; SrcAE = '0; SrcBE = '0;
      tick(); tick();
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q", QuotientE, 32'd0);
      check("rst_r", RemainderE, 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      do_div("udiv_100_7",  UDIV_OP, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
      do_div("sdiv_m100_7", SDIV_OP, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      do_div("sdiv_100_m7", SDIV_OP, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 1'b0);
      do_div("sdiv_m7_m2",  SDIV_OP, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      do_div("sdiv_min_m1", SDIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0);
      do_div("udiv_big_16", UDIV_OP, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, 1'b0, 1'b0);
      do_div("udiv_55_0",   UDIV_OP, 32'd55, 32'd0, 32'd0, 32'd55, 1'b1, 1'b1, 1'b0);
      do_div("udiv_5_9",    UDIV_OP, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b1, 1'b0);
      do_div("sdiv_hold",   SDIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
      expect_quiet("after_hold", 40);

      // Cancel while iterating: busy drops at once and the divide never completes.
      start = 1'b1; ALUControlE = UDIV_OP; SrcAE = 32'd100; SrcBE = 32'd7;
      tick();
      start = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      cancel = 1'b1;
      @(negedge clk);
      check("cancel_busy", 32'(busy), 32'd0);
      tick();
      cancel = 1'b0;
      expect_quiet("cancel", 40);
      do_div("udiv_9_3",    UDIV_OP, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);

      // Cancel in the DONE cycle: no pulse and held results stay at 9/3.
      start = 1'b1; ALUControlE = UDIV_OP; SrcAE = 32'd100; SrcBE = 32'd7;
      tick();
      start = 1'b0;
      for (int k = 1; k < 33; k++) tick();
      cancel = 1'b1;
      @(negedge clk);
      check("cdone_done", 32'(done), 32'd0);
      check("cdone_q", QuotientE, 32'd3);
      tick();
      cancel = 1'b0;
      @(negedge clk);
      check("cdone_q_after", QuotientE, 32'd3);
      check("cdone_r_after", RemainderE, 32'd0);
      tick();

      // Reset mid-operation after a divide that left nonzero, sticky results.
      do_div("sdiv_m5_0",   SDIV_OP, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0);
      start = 1'b1; ALUControlE = UDIV_OP; SrcAE = 32'd100; SrcBE = 32'd7;
      tick();
      start = 1'b0;
      for (int k = 1; k < 5; k++) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_q", QuotientE, 32'd0);
      check("mrst_r", RemainderE, 32'd0);
      check("mrst_dbz", 32'(div_by_zero), 32'd0);
      tick();
      expect_quiet("mrst", 40);

      // Non-divide opcode with start is ignored.
      start = 1'b1; ALUControlE = ADD_OP; SrcAE = 32'd100; SrcBE = 32'd7;
      @(negedge clk);
      check("add_busy", 32'(busy), 32'd0);
      tick();
      start = 1'b0;
      expect_quiet("add", 40);
      do_div("udiv_after",  UDIV_OP, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
